// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tape_pkg
// Description : Shared definitions for the paper-tape read controller:
//               one-hot controller state encoding, tape character width and
//               assembly-mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package tape_pkg;

    // Physical tape character width (5-hole tape).
    localparam int CHAR_W = 5;

    // Number of low character bits kept in 4-bit assemble mode.
    localparam int B4_W = 4;

    // Assembly modes carried on cmd_mode.
    localparam logic MODE_B5 = 1'b0;
    localparam logic MODE_B4 = 1'b1;

    // One-hot controller state.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_LOAD    = 5'b00010,
        ST_REQ     = 5'b00100,
        ST_RELEASE = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tape_char_hs.sv
`default_nettype none
// ============================================================================
// Module      : tape_char_hs
// Description : Per-character request half of the tape reader handshake.
//               Owns the registered request line and the REQ timeout timer.
//               A start pulse raises input_rdy on the next cycle and clears
//               the timer; input_rdy drops on the same edge that a character
//               is captured or the timer expires.
// Ports       : clk, resetn      - clock, synchronous active-low reset
//               start            - begin a character request
//               input_val/_data  - tape reader valid / character
//               input_rdy        - registered request to the reader
//               char_val         - capture strobe (request open, val seen)
//               char_data        - character to capture
//               timeout          - request window expired without a character
// Revision    : 1.0 - initial release
// ============================================================================
module tape_char_hs #(
    parameter int CHAR_W  = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              input_val,
    input  logic [CHAR_W-1:0] input_data,
    output logic              input_rdy,
    output logic              char_val,
    output logic [CHAR_W-1:0] char_data,
    output logic              timeout
);

    localparam int c_TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

    logic                 rdy_q;
    logic                 rdy_d;
    logic [c_TIMER_W-1:0] timer_q;
    logic [c_TIMER_W-1:0] timer_d;

    // rdy_q is high exactly while the request window is open, so it doubles
    // as the "in REQ" qualifier for capture and timeout.
    always_comb begin
        char_val  = rdy_q & input_val;
        char_data = input_data;
        timeout   = rdy_q & ~input_val & (timer_q == c_TIMER_LAST);
        rdy_d     = rdy_q;
        timer_d   = timer_q;
        if (start) begin
            rdy_d   = 1'b1;
            timer_d = '0;
        end else if (rdy_q) begin
            timer_d = timer_q + 1'b1;
            if (char_val || timeout) begin
                rdy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            rdy_q   <= rdy_d;
            timer_q <= timer_d;
        end
    end

    assign input_rdy = rdy_q;

endmodule
`default_nettype wire

// File: rtl/tape_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tape_read_ctrl
// Description : Paper-tape read controller. Accepts "read N characters"
//               commands, sequences one reader handshake per character,
//               shift-assembles the characters (first read ends up most
//               significant) and returns the word plus a timeout flag on a
//               valid/ready response port.
// Ports       : clk, resetn           - clock, synchronous active-low reset
//               cmd_val/cmd_rdy       - command handshake
//               cmd_cnt, cmd_mode     - character count, 0=5-bit / 1=4-bit
//               rsp_val/rsp_rdy       - response handshake
//               rsp_data, rsp_err     - assembled word, timeout flag
//               busy                  - command in progress
//               input_rdy/input_val   - tape reader handshake
//               input_data            - tape character
// Revision    : 1.0 - initial release
// ============================================================================
module tape_read_ctrl #(
    parameter int WORD_W  = 32,
    parameter int CHAR_W  = tape_pkg::CHAR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [2:0]        cmd_cnt,
    input  logic              cmd_mode,
    output logic              rsp_val,
    input  logic              rsp_rdy,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              input_rdy,
    input  logic              input_val,
    input  logic [CHAR_W-1:0] input_data
);

    import tape_pkg::*;

    state_t              state_q;
    state_t              state_d;

    logic                cmd_rdy_q, cmd_rdy_d;
    logic                busy_q, busy_d;
    logic                rsp_val_q, rsp_val_d;
    logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [2:0]          remaining_q, remaining_d;
    logic                mode_q, mode_d;
    logic                err_q, err_d;

    logic                w_start;
    logic                w_enter_done;
    logic                w_accept;
    logic                w_char_val;
    logic [CHAR_W-1:0]   w_char_data;
    logic                w_timeout;
    logic [WORD_W-1:0]   w_acc_shift;

    tape_char_hs #(
        .CHAR_W  (CHAR_W),
        .TIMEOUT (TIMEOUT)
    ) u_char_hs (
        .clk        (clk),
        .resetn     (resetn),
        .start      (w_start),
        .input_val  (input_val),
        .input_data (input_data),
        .input_rdy  (input_rdy),
        .char_val   (w_char_val),
        .char_data  (w_char_data),
        .timeout    (w_timeout)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commands are taken only while the registered cmd_rdy is up, so the
    // single cycle after reset release (cmd_rdy still low) cannot accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_val && cmd_rdy_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (remaining_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_char_val) begin
                    state_d = ST_RELEASE;
                end else if (w_timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_RELEASE: begin
                if (!input_val) begin
                    if (remaining_q != 3'd0) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Registered outputs are computed from the next state so they line up
    // with the state they describe.
    always_comb begin
        cmd_rdy_d    = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        rsp_val_d    = (state_d == ST_DONE);
        w_accept     = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        w_start      = (state_d == ST_REQ) && (state_q != ST_REQ);
        w_enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // ------------------------------------------------------------- datapath
    // Shift left by the character width in use; bits above WORD_W fall off.
    always_comb begin
        if (mode_q == MODE_B5) begin
            w_acc_shift = {acc_q[WORD_W-CHAR_W-1:0], w_char_data};
        end else begin
            w_acc_shift = {acc_q[WORD_W-B4_W-1:0], w_char_data[B4_W-1:0]};
        end
    end

    always_comb begin
        acc_d       = acc_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        err_d       = err_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (w_accept) begin
            remaining_d = cmd_cnt;
            mode_d      = cmd_mode;
            acc_d       = '0;
            err_d       = 1'b0;
        end
        if ((state_q == ST_REQ) && w_char_val) begin
            acc_d       = w_acc_shift;
            remaining_d = remaining_q - 1'b1;
        end
        if ((state_q == ST_REQ) && w_timeout) begin
            err_d = 1'b1;
        end
        // Snapshot on entry so the response stays stable while held in DONE.
        if (w_enter_done) begin
            rsp_data_d = acc_d;
            rsp_err_d  = err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_val_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            acc_q       <= '0;
            remaining_q <= 3'd0;
            mode_q      <= MODE_B5;
            err_q       <= 1'b0;
        end else begin
            cmd_rdy_q   <= cmd_rdy_d;
            busy_q      <= busy_d;
            rsp_val_q   <= rsp_val_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
        end
    end

    assign cmd_rdy  = cmd_rdy_q;
    assign busy     = busy_q;
    assign rsp_val  = rsp_val_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tape_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_read_ctrl
// Description : Self-checking bench for tape_read_ctrl. A behavioural tape
//               reader answers input_rdy from a character queue; expected
//               responses are queued when each command is issued and
//               compared when the response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_read_ctrl;

    localparam int WORD_W  = 32;
    localparam int CHAR_W  = 5;
    localparam int TIMEOUT = 16;

    logic              clk        = 1'b0;
    logic              resetn     = 1'b0;
    logic              cmd_val    = 1'b0;
    logic [2:0]        cmd_cnt    = 3'd0;
    logic              cmd_mode   = 1'b0;
    logic              rsp_rdy    = 1'b0;
    logic              input_val  = 1'b0;
    logic [CHAR_W-1:0] input_data = '0;
    logic              cmd_rdy;
    logic              rsp_val;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              input_rdy;

    tape_read_ctrl #(
        .WORD_W  (WORD_W),
        .CHAR_W  (CHAR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_val    (cmd_val),
        .cmd_rdy    (cmd_rdy),
        .cmd_cnt    (cmd_cnt),
        .cmd_mode   (cmd_mode),
        .rsp_val    (rsp_val),
        .rsp_rdy    (rsp_rdy),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .input_rdy  (input_rdy),
        .input_val  (input_val),
        .input_data (input_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WORD_W:0]   exp_q[$];   // {err, data}
    logic [CHAR_W-1:0] tape_q[$];
    int                hold_q[$];  // extra cycles to hold val per character

    int   rdy_pulses = 0;
    int   rdy_cycles = 0;
    logic rdy_prev   = 1'b0;

    // Request activity monitor, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (input_rdy && !rdy_prev) rdy_pulses++;
        if (input_rdy) rdy_cycles++;
        rdy_prev = input_rdy;
    end

    // Tape reader: answers an open request on the falling edge, drops val
    // once the request is withdrawn (optionally after some extra cycles).
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                input_val = 1'b0;
                hold      = 0;
            end else if (!input_val) begin
                if (input_rdy && tape_q.size() > 0) begin
                    input_data = tape_q.pop_front();
                    hold       = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
                    input_val  = 1'b1;
                end
            end else begin
                if (hold > 0) hold--;
                else if (!input_rdy) input_val = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] model(input logic [CHAR_W-1:0] ch[$], input logic mode);
        logic [63:0] a;
        a = 64'd0;
        foreach (ch[i]) begin
            if (mode) a = (a << 4) | 64'(ch[i][3:0]);
            else      a = (a << 5) | 64'(ch[i]);
        end
        return a[WORD_W-1:0];
    endfunction

    task automatic send_cmd(input string tag, input logic [2:0] cnt, input logic mode,
                            input logic [WORD_W-1:0] exp_data, input logic exp_err);
        int n;
        n = 0;
        while (!cmd_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'd1);
        cmd_val  = 1'b1;
        cmd_cnt  = cnt;
        cmd_mode = mode;
        exp_q.push_back({exp_err, exp_data});
        rdy_pulses = 0;
        rdy_cycles = 0;
        @(negedge clk);
        cmd_val = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int stall);
        int          n;
        logic [WORD_W:0] e;
        logic        stable;
        n = 0;
        while (!rsp_val && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_val"}, 64'(rsp_val), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(e[WORD_W-1:0]));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(e[WORD_W]));
        if (stall > 0) begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                cmd_val = i[0];
                cmd_cnt = 3'd3;
                @(negedge clk);
                if (!(rsp_val === 1'b1 && rsp_data === e[WORD_W-1:0] &&
                      rsp_err === e[WORD_W] && input_rdy === 1'b0)) stable = 1'b0;
            end
            cmd_val = 1'b0;
            check({tag, "_held_stable"}, 64'(stable), 64'd1);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        check({tag, "_rsp_drop"}, 64'(rsp_val), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [CHAR_W-1:0] chars[$];
        logic [WORD_W-1:0] e7;

        // Reset values
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("rst_rsp_val", 64'(rsp_val), 64'd0);
        check("rst_input_rdy", 64'(input_rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        resetn = 1'b1;

        // Single 5-bit character; request opens two cycles after accept
        tape_q.push_back(5'h15);
        send_cmd("t1", 3'd1, 1'b0, 32'h0000_0015, 1'b0);
        check("t1_rdy_load", 64'(input_rdy), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_rdy_t2", 64'(input_rdy), 64'd1);
        get_rsp("t1", 0);
        check("t1_pulses", 64'(rdy_pulses), 64'd1);

        // Three characters, second one held valid for four cycles
        tape_q.push_back(5'h01); hold_q.push_back(0);
        tape_q.push_back(5'h02); hold_q.push_back(3);
        tape_q.push_back(5'h1F); hold_q.push_back(0);
        send_cmd("t2", 3'd3, 1'b0, 32'h0000_045F, 1'b0);
        get_rsp("t2", 0);
        check("t2_pulses", 64'(rdy_pulses), 64'd3);
        check("t2_tape_used", 64'(tape_q.size()), 64'd0);

        // 4-bit mode drops bit 4 of each character
        tape_q.push_back(5'h1A);
        tape_q.push_back(5'h13);
        send_cmd("t3", 3'd2, 1'b1, 32'h0000_00A3, 1'b0);
        get_rsp("t3", 0);
        check("t3_pulses", 64'(rdy_pulses), 64'd2);

        // Zero-length read: response two cycles after accept, no requests
        send_cmd("t4", 3'd0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t4_rsp_t2", 64'(rsp_val), 64'd1);
        get_rsp("t4", 0);
        check("t4_no_rdy", 64'(rdy_cycles), 64'd0);

        // Timeout with reader silent: TIMEOUT request cycles then error
        send_cmd("t5", 3'd2, 1'b0, 32'h0, 1'b1);
        get_rsp("t5", 0);
        check("t5_req_cycles", 64'(rdy_cycles), 64'(TIMEOUT));
        check("t5_rdy_low", 64'(input_rdy), 64'd0);

        // Timeout after one good character keeps the partial word
        tape_q.push_back(5'h07);
        send_cmd("t6", 3'd2, 1'b0, 32'h0000_0007, 1'b1);
        get_rsp("t6", 0);
        check("t6_req_cycles", 64'(rdy_cycles), 64'(TIMEOUT + 1));
        check("t6_pulses", 64'(rdy_pulses), 64'd2);

        // Seven 5-bit characters: top three bits of the 35 are dropped
        chars = '{5'h1F, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06};
        foreach (chars[i]) tape_q.push_back(chars[i]);
        e7 = model(chars, 1'b0);
        send_cmd("t7", 3'd7, 1'b0, e7, 1'b0);
        get_rsp("t7", 0);
        check("t7_pulses", 64'(rdy_pulses), 64'd7);

        // Response backpressure with stray commands in the window
        tape_q.push_back(5'h0A);
        send_cmd("t8", 3'd1, 1'b1, 32'h0000_000A, 1'b0);
        get_rsp("t8", 10);
        @(negedge clk);
        check("t8_no_ghost_cmd", 64'(busy), 64'd0);

        // Reset during a request, then a clean command
        send_cmd("t9", 3'd5, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t9_in_req", 64'(input_rdy), 64'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("t9_rst_rdy", 64'(input_rdy), 64'd0);
        check("t9_rst_rsp", 64'(rsp_val), 64'd0);
        check("t9_rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        exp_q.delete();
        tape_q.push_back(5'h11);
        send_cmd("t10", 3'd1, 1'b0, 32'h0000_0011, 1'b0);
        get_rsp("t10", 0);
        check("t10_pulses", 64'(rdy_pulses), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
